// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// Module   : mc_control
// Purpose  : Main control FSM for a multicycle MIPS datapath. It steps each
//            instruction through fetch/decode/execute/memory/writeback and
//            drives the ALU, memory, IR, register-file and PC controls.
// Revision : 1.0 - initial release
// ============================================================================
module mc_control #(
  parameter int ALU_CTRL_W = 4,
  parameter int STATE_W    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [5:0]            i_opcode,
  input  logic [5:0]            i_funct,
  input  logic                  i_zf,
  output logic [ALU_CTRL_W-1:0] o_alu_control,
  output logic                  o_alusrca,
  output logic [1:0]            o_alusrcb,
  output logic                  o_iord,
  output logic                  o_memwrite,
  output logic                  o_irwrite,
  output logic                  o_regwrite,
  output logic                  o_regdst,
  output logic                  o_memtoreg,
  output logic [1:0]            o_pcsrc,
  output logic                  o_pcwrite_en,
  output logic [STATE_W-1:0]    o_state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
  } state_t;

  localparam logic [ALU_CTRL_W-1:0] c_ALU_AND = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] c_ALU_OR  = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] c_ALU_ADD = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] c_ALU_SUB = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] c_ALU_SLT = ALU_CTRL_W'(4);
  localparam logic [ALU_CTRL_W-1:0] c_ALU_NOR = ALU_CTRL_W'(5);

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;

  state_t state_q, state_d;

  logic [ALU_CTRL_W-1:0] w_fn_alu;
  logic                  w_fn_ok;

  logic [ALU_CTRL_W-1:0] w_alu_control;
  logic                  w_alusrca;
  logic [1:0]            w_alusrcb;
  logic                  w_iord;
  logic                  w_memwrite;
  logic                  w_irwrite;
  logic                  w_regwrite;
  logic                  w_regdst;
  logic                  w_memtoreg;
  logic [1:0]            w_pcsrc;
  logic                  w_pcwrite_en;

  // State register; reset always restarts the instruction at FETCH.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // R-type funct decode; an unknown funct runs as ADD but must not write back.
  always_comb begin
    w_fn_alu = c_ALU_ADD;
    w_fn_ok  = 1'b1;
    case (i_funct)
      6'h20:   w_fn_alu = c_ALU_ADD;
      6'h22:   w_fn_alu = c_ALU_SUB;
      6'h24:   w_fn_alu = c_ALU_AND;
      6'h25:   w_fn_alu = c_ALU_OR;
      6'h27:   w_fn_alu = c_ALU_NOR;
      6'h2A:   w_fn_alu = c_ALU_SLT;
      default: w_fn_ok  = 1'b0;
    endcase
  end

  // Next-state and Moore outputs; only BRANCH looks at the zero flag.
  always_comb begin
    state_d       = FETCH;
    w_alu_control = c_ALU_ADD;
    w_alusrca     = 1'b0;
    w_alusrcb     = 2'b00;
    w_iord        = 1'b0;
    w_memwrite    = 1'b0;
    w_irwrite     = 1'b0;
    w_regwrite    = 1'b0;
    w_regdst      = 1'b0;
    w_memtoreg    = 1'b0;
    w_pcsrc       = 2'b00;
    w_pcwrite_en  = 1'b0;
    case (state_q)
      FETCH: begin
        state_d      = DECODE;
        w_alusrcb    = 2'b01;
        w_irwrite    = 1'b1;
        w_pcwrite_en = 1'b1;
      end
      DECODE: begin
        w_alusrcb = 2'b11;   // branch target computed speculatively
        case (i_opcode)
          c_OP_LW, c_OP_SW: state_d = MEMADR;
          c_OP_RTYPE:       state_d = EXEC;
          c_OP_BEQ:         state_d = BRANCH;
          c_OP_ADDI:        state_d = ADDIEX;
          c_OP_J:           state_d = JUMP;
          default:          state_d = FETCH;
        endcase
      end
      MEMADR: begin
        state_d   = (i_opcode == c_OP_LW) ? MEMRD : MEMWR;
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      MEMRD: begin
        state_d = MEMWB;
        w_iord  = 1'b1;
      end
      MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      EXEC: begin
        state_d       = ALUWB;
        w_alusrca     = 1'b1;
        w_alu_control = w_fn_alu;
      end
      ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = w_fn_ok;
      end
      BRANCH: begin
        w_alusrca     = 1'b1;
        w_alu_control = c_ALU_SUB;
        w_pcsrc       = 2'b01;
        w_pcwrite_en  = i_zf;
      end
      ADDIEX: begin
        state_d   = ADDIWB;
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      ADDIWB: begin
        w_regwrite = 1'b1;
      end
      JUMP: begin
        w_pcsrc      = 2'b10;
        w_pcwrite_en = 1'b1;
      end
      default: state_d = FETCH;   // codes 12-15 recover on the next edge
    endcase
  end

  // Reset blanks every strobe so an aborted instruction writes nothing.
  assign o_alu_control = i_rst ? '0 : w_alu_control;
  assign o_alusrca     = i_rst ? 1'b0 : w_alusrca;
  assign o_alusrcb     = i_rst ? 2'b00 : w_alusrcb;
  assign o_iord        = i_rst ? 1'b0 : w_iord;
  assign o_memwrite    = i_rst ? 1'b0 : w_memwrite;
  assign o_irwrite     = i_rst ? 1'b0 : w_irwrite;
  assign o_regwrite    = i_rst ? 1'b0 : w_regwrite;
  assign o_regdst      = i_rst ? 1'b0 : w_regdst;
  assign o_memtoreg    = i_rst ? 1'b0 : w_memtoreg;
  assign o_pcsrc       = i_rst ? 2'b00 : w_pcsrc;
  assign o_pcwrite_en  = i_rst ? 1'b0 : w_pcwrite_en;
  assign o_state       = STATE_W'(state_q);

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control
// Purpose  : Scoreboard bench for mc_control. The driver expands each
//            instruction into its expected per-cycle control vectors; a
//            monitor compares the DUT against them on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] alu;
    logic       srca;
    logic [1:0] srcb;
    logic       iord;
    logic       memw;
    logic       irw;
    logic       regw;
    logic       regdst;
    logic       m2r;
    logic [1:0] pcsrc;
    logic       pcwe;
  } exp_t;

  typedef struct {
    exp_t  v;
    string nm;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zf;
  logic [3:0] alu_control;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       iord, memwrite, irwrite, regwrite, regdst, memtoreg, pcwrite_en;
  logic [1:0] pcsrc;
  logic [3:0] state;

  rec_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  mc_control #(.ALU_CTRL_W(4), .STATE_W(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_opcode      (opcode),
    .i_funct       (funct),
    .i_zf          (zf),
    .o_alu_control (alu_control),
    .o_alusrca     (alusrca),
    .o_alusrcb     (alusrcb),
    .o_iord        (iord),
    .o_memwrite    (memwrite),
    .o_irwrite     (irwrite),
    .o_regwrite    (regwrite),
    .o_regdst      (regdst),
    .o_memtoreg    (memtoreg),
    .o_pcsrc       (pcsrc),
    .o_pcwrite_en  (pcwrite_en),
    .o_state       (state)
  );

  always #5 clk = ~clk;

  // Monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      rec_t r;
      exp_t a;
      r = q.pop_front();
      a = '{st: state, alu: alu_control, srca: alusrca, srcb: alusrcb,
            iord: iord, memw: memwrite, irw: irwrite, regw: regwrite,
            regdst: regdst, m2r: memtoreg, pcsrc: pcsrc, pcwe: pcwrite_en};
      n_cmp++;
      if (a !== r.v) begin
        n_bad++;
        $display("FAIL %s: state=%0d got={st,alu,srca,srcb,iord,memw,irw,regw,regdst,m2r,pcsrc,pcwe}=%b expected=%b",
                 r.nm, state, a, r.v);
      end
    end
  end

  // Idle vector for a given state: nothing enabled, ALU defaults to ADD.
  function automatic exp_t base(input logic [3:0] st);
    exp_t e;
    e     = '0;
    e.st  = st;
    e.alu = 4'd2;
    return e;
  endfunction

  task automatic step(input exp_t e, input string nm);
    rec_t r;
    r.v  = e;
    r.nm = nm;
    q.push_back(r);
    @(posedge clk);
    #1;
  endtask

  // Reference model: the full cycle-by-cycle control trace of one instruction.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input string nm);
    exp_t       seq[$];
    exp_t       e;
    logic [3:0] fa;
    bit         fok;
    fok = 1'b1;
    case (fn)
      6'h20:   fa = 4'd2;
      6'h22:   fa = 4'd3;
      6'h24:   fa = 4'd0;
      6'h25:   fa = 4'd1;
      6'h27:   fa = 4'd5;
      6'h2A:   fa = 4'd4;
      default: begin fa = 4'd2; fok = 1'b0; end
    endcase
    opcode = op;
    funct  = fn;
    zf     = z;
    e = base(4'd0); e.srcb = 2'b01; e.irw = 1'b1; e.pcwe = 1'b1; seq.push_back(e);
    e = base(4'd1); e.srcb = 2'b11; seq.push_back(e);
    case (op)
      6'h23: begin
        e = base(4'd2); e.srca = 1'b1; e.srcb = 2'b10; seq.push_back(e);
        e = base(4'd3); e.iord = 1'b1; seq.push_back(e);
        e = base(4'd4); e.m2r = 1'b1; e.regw = 1'b1; seq.push_back(e);
      end
      6'h2B: begin
        e = base(4'd2); e.srca = 1'b1; e.srcb = 2'b10; seq.push_back(e);
        e = base(4'd5); e.iord = 1'b1; e.memw = 1'b1; seq.push_back(e);
      end
      6'h00: begin
        e = base(4'd6); e.srca = 1'b1; e.alu = fa; seq.push_back(e);
        e = base(4'd7); e.regdst = 1'b1; e.regw = fok; seq.push_back(e);
      end
      6'h04: begin
        e = base(4'd8); e.srca = 1'b1; e.alu = 4'd3; e.pcsrc = 2'b01; e.pcwe = z;
        seq.push_back(e);
      end
      6'h08: begin
        e = base(4'd9); e.srca = 1'b1; e.srcb = 2'b10; seq.push_back(e);
        e = base(4'd10); e.regw = 1'b1; seq.push_back(e);
      end
      6'h02: begin
        e = base(4'd11); e.pcsrc = 2'b10; e.pcwe = 1'b1; seq.push_back(e);
      end
      default: ;
    endcase
    foreach (seq[i]) step(seq[i], nm);
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] ops [6];
    logic [5:0] o;
    ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02};
    if ($urandom_range(0, 6) < 6) return ops[$urandom_range(0, 5)];
    do o = 6'($urandom_range(0, 63));
    while (o == 6'h23 || o == 6'h2B || o == 6'h00 || o == 6'h04 || o == 6'h08 || o == 6'h02);
    return o;
  endfunction

  function automatic logic [5:0] pick_fn();
    logic [5:0] fns [6];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    if ($urandom_range(0, 4) == 0) return 6'($urandom_range(0, 63));
    return fns[$urandom_range(0, 5)];
  endfunction

  initial begin
    exp_t z0;
    rst    = 1'b1;
    opcode = 6'h00;
    funct  = 6'h20;
    zf     = 1'b0;
    @(posedge clk);
    #1;
    // Held in reset: state already FETCH, every other output blanked.
    z0 = '0;
    repeat (3) step(z0, "reset");
    rst = 1'b0;

    run_instr(6'h23, 6'h00, 1'b0, "lw");
    run_instr(6'h00, 6'h22, 1'b0, "r_sub");
    run_instr(6'h04, 6'h00, 1'b1, "beq_taken");
    run_instr(6'h04, 6'h00, 1'b0, "beq_not_taken");
    run_instr(6'h3F, 6'h00, 1'b1, "unknown_op");
    run_instr(6'h00, 6'h3F, 1'b0, "unknown_funct");
    run_instr(6'h08, 6'h11, 1'b1, "addi");
    run_instr(6'h02, 6'h00, 1'b0, "j");
    run_instr(6'h2B, 6'h00, 1'b0, "sw");

    // sw aborted by reset while in MEMADR: store must never be issued.
    opcode = 6'h2B;
    funct  = 6'h00;
    begin
      exp_t e;
      e = base(4'd0); e.srcb = 2'b01; e.irw = 1'b1; e.pcwe = 1'b1; step(e, "sw_rst_fetch");
      e = base(4'd1); e.srcb = 2'b11; step(e, "sw_rst_decode");
      rst = 1'b1;
      e = '0; e.st = 4'd2; step(e, "sw_rst_memadr");
      rst = 1'b0;
    end
    run_instr(6'h00, 6'h25, 1'b0, "after_reset_or");

    for (int k = 0; k < 300; k++)
      run_instr(pick_op(), pick_fn(), 1'($urandom_range(0, 1)), "random");

    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d leftover expectations, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
